// File: rtl/modulation_gen_ms.sv
// -----------------------------------------------------------------------------
// modulation_gen_ms
//   Stepped modulation generator. Sequences through two steps (0,1) or four
//   steps (0..3). Each step lasts max(freq_cnt,1) clocks and drives a
//   programmable signed level. Configuration is captured into shadow
//   registers at run start and at every wrap back to step 0, so changes made
//   mid-cycle only take effect from the next cycle.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset; the block leaves reset idle
//   i_en           run enable (low = idle, outputs forced to 0)
//   i_mode         0 = two-state sequence, 1 = four-state sequence
//   i_freq_cnt     dwell per step in clocks (0 treated as 1)
//   i_amp0..3      signed level for steps 0..3
//   i_trig_dly     sample-trigger offset within each step
//   o_mod_out      registered modulation level
//   o_step         current step index
//   o_status       1 = positive half-cycle, 0 = negative half-cycle
//   o_stepTrig     pulse on the first clock of each step
//   o_sampTrig     pulse at offset i_trig_dly within each step
//   o_cycle_done   pulse on the edge the sequence wraps to step 0
//   o_dbg_running  debug view of the run/idle state register
//
// Handshake: there is no valid/ready handshake; i_en is a level that is
// sampled on every rising edge, and every output is a registered level or a
// single-clock pulse that is valid for the whole clock after the edge.
// -----------------------------------------------------------------------------
module modulation_gen_ms #(
   parameter int DW = 32,
   parameter int CW = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_en,
   input  logic                 i_mode,
   input  logic [CW-1:0]        i_freq_cnt,
   input  logic signed [DW-1:0] i_amp0,
   input  logic signed [DW-1:0] i_amp1,
   input  logic signed [DW-1:0] i_amp2,
   input  logic signed [DW-1:0] i_amp3,
   input  logic [CW-1:0]        i_trig_dly,
   output logic signed [DW-1:0] o_mod_out,
   output logic [1:0]           o_step,
   output logic                 o_status,
   output logic                 o_stepTrig,
   output logic                 o_sampTrig,
   output logic                 o_cycle_done,
   output logic                 o_dbg_running
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           step_q, step_d;
   logic signed [DW-1:0] mod_q, mod_d;
   logic                 status_q, status_d;
   logic                 step_trig_q, step_trig_d;
   logic                 samp_trig_q, samp_trig_d;
   logic                 done_q, done_d;

   // shadow configuration
   logic                 sh_mode_q, sh_mode_d;
   logic [CW-1:0]        sh_freq_q, sh_freq_d;
   logic [CW-1:0]        sh_trig_q, sh_trig_d;
   logic signed [DW-1:0] sh_amp0_q, sh_amp0_d;
   logic signed [DW-1:0] sh_amp1_q, sh_amp1_d;
   logic signed [DW-1:0] sh_amp2_q, sh_amp2_d;
   logic signed [DW-1:0] sh_amp3_q, sh_amp3_d;

   logic [CW-1:0]        cnt_last;
   logic [CW-1:0]        cnt_inc;
   logic [1:0]           step_nxt;
   logic signed [DW-1:0] amp_nxt;

   // Last counter value of a step is F-1 with F = max(freq,1); a zero dwell
   // therefore collapses to a single-clock step.
   assign cnt_last = (sh_freq_q == '0) ? '0 : (sh_freq_q - CW'(1));
   // Only used when cnt_q < cnt_last, so it cannot overflow.
   assign cnt_inc  = cnt_q + CW'(1);

   // Two-state toggles bit 0 only, so the step index can never exceed 1.
   assign step_nxt = sh_mode_q ? (step_q + 2'd1) : {1'b0, ~step_q[0]};

   always_comb begin
      amp_nxt = sh_amp0_q;
      case (step_nxt)
         2'd0: amp_nxt = sh_amp0_q;
         2'd1: amp_nxt = sh_amp1_q;
         2'd2: amp_nxt = sh_amp2_q;
         2'd3: amp_nxt = sh_amp3_q;
         default: amp_nxt = sh_amp0_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      step_d      = step_q;
      mod_d       = mod_q;
      status_d    = status_q;
      step_trig_d = 1'b0;
      samp_trig_d = 1'b0;
      done_d      = 1'b0;
      sh_mode_d   = sh_mode_q;
      sh_freq_d   = sh_freq_q;
      sh_trig_d   = sh_trig_q;
      sh_amp0_d   = sh_amp0_q;
      sh_amp1_d   = sh_amp1_q;
      sh_amp2_d   = sh_amp2_q;
      sh_amp3_d   = sh_amp3_q;

      if (!i_en) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         step_d   = 2'd0;
         mod_d    = '0;
         status_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d     = S_RUN;
               sh_mode_d   = i_mode;
               sh_freq_d   = i_freq_cnt;
               sh_trig_d   = i_trig_dly;
               sh_amp0_d   = i_amp0;
               sh_amp1_d   = i_amp1;
               sh_amp2_d   = i_amp2;
               sh_amp3_d   = i_amp3;
               cnt_d       = '0;
               step_d      = 2'd0;
               mod_d       = i_amp0;
               status_d    = 1'b1;
               step_trig_d = 1'b1;
               samp_trig_d = (i_trig_dly == '0);
            end
            S_RUN: begin
               if (cnt_q < cnt_last) begin
                  cnt_d       = cnt_inc;
                  samp_trig_d = (cnt_inc == sh_trig_q);
               end else begin
                  cnt_d       = '0;
                  step_d      = step_nxt;
                  step_trig_d = 1'b1;
                  if (step_nxt == 2'd0) begin
                     // Wrap: new cycle runs entirely on freshly captured config.
                     sh_mode_d   = i_mode;
                     sh_freq_d   = i_freq_cnt;
                     sh_trig_d   = i_trig_dly;
                     sh_amp0_d   = i_amp0;
                     sh_amp1_d   = i_amp1;
                     sh_amp2_d   = i_amp2;
                     sh_amp3_d   = i_amp3;
                     mod_d       = i_amp0;
                     status_d    = 1'b1;
                     done_d      = 1'b1;
                     samp_trig_d = (i_trig_dly == '0);
                  end else begin
                     mod_d       = amp_nxt;
                     status_d    = sh_mode_q && (step_nxt == 2'd1);
                     samp_trig_d = (sh_trig_q == '0);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         step_q      <= 2'd0;
         mod_q       <= '0;
         status_q    <= 1'b0;
         step_trig_q <= 1'b0;
         samp_trig_q <= 1'b0;
         done_q      <= 1'b0;
         sh_mode_q   <= 1'b0;
         sh_freq_q   <= '0;
         sh_trig_q   <= '0;
         sh_amp0_q   <= '0;
         sh_amp1_q   <= '0;
         sh_amp2_q   <= '0;
         sh_amp3_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         step_q      <= step_d;
         mod_q       <= mod_d;
         status_q    <= status_d;
         step_trig_q <= step_trig_d;
         samp_trig_q <= samp_trig_d;
         done_q      <= done_d;
         sh_mode_q   <= sh_mode_d;
         sh_freq_q   <= sh_freq_d;
         sh_trig_q   <= sh_trig_d;
         sh_amp0_q   <= sh_amp0_d;
         sh_amp1_q   <= sh_amp1_d;
         sh_amp2_q   <= sh_amp2_d;
         sh_amp3_q   <= sh_amp3_d;
      end
   end

   assign o_mod_out     = mod_q;
   assign o_step        = step_q;
   assign o_status      = status_q;
   assign o_stepTrig    = step_trig_q;
   assign o_sampTrig    = samp_trig_q;
   assign o_cycle_done  = done_q;
   assign o_dbg_running = (state_q == S_RUN);

endmodule

// File: tb/tb_modulation_gen_ms.sv
// -----------------------------------------------------------------------------
// tb_modulation_gen_ms
//   Self-checking bench for modulation_gen_ms. The reference model tracks the
//   position k inside the whole cycle (0 .. nsteps*F-1) and derives step,
//   in-step index and all outputs from it arithmetically.
// -----------------------------------------------------------------------------
module tb_modulation_gen_ms;

   localparam int DW = 32;
   localparam int CW = 32;

   // ---------------- clock / reset ----------------
   logic i_clk = 1'b0;
   logic i_rst_n = 1'b0;
   always #5 i_clk = ~i_clk;

   logic                 i_en = 1'b0;
   logic                 i_mode = 1'b0;
   logic [CW-1:0]        i_freq_cnt = '0;
   logic signed [DW-1:0] i_amp0 = '0, i_amp1 = '0, i_amp2 = '0, i_amp3 = '0;
   logic [CW-1:0]        i_trig_dly = '0;
   logic signed [DW-1:0] o_mod_out;
   logic [1:0]           o_step;
   logic                 o_status, o_stepTrig, o_sampTrig, o_cycle_done, o_dbg_running;

   modulation_gen_ms #(.DW(DW), .CW(CW)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_en         (i_en),
      .i_mode       (i_mode),
      .i_freq_cnt   (i_freq_cnt),
      .i_amp0       (i_amp0),
      .i_amp1       (i_amp1),
      .i_amp2       (i_amp2),
      .i_amp3       (i_amp3),
      .i_trig_dly   (i_trig_dly),
      .o_mod_out    (o_mod_out),
      .o_step       (o_step),
      .o_status     (o_status),
      .o_stepTrig   (o_stepTrig),
      .o_sampTrig   (o_sampTrig),
      .o_cycle_done (o_cycle_done),
      .o_dbg_running(o_dbg_running)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit                   m_run;
   longint               m_k;
   bit                   sh_mode;
   longint               sh_freq, sh_trig;
   logic signed [DW-1:0] sh_amp[4];
   logic signed [DW-1:0] e_mod;
   logic [1:0]           e_step;
   bit                   e_status, e_st, e_sp, e_done;

   function automatic longint dwell();
      return (sh_freq == 0) ? 64'sd1 : sh_freq;
   endfunction

   function automatic longint nsteps();
      return sh_mode ? 64'sd4 : 64'sd2;
   endfunction

   task automatic model_load();
      sh_mode   = i_mode;
      sh_freq   = longint'({32'd0, i_freq_cnt});
      sh_trig   = longint'({32'd0, i_trig_dly});
      sh_amp[0] = i_amp0;
      sh_amp[1] = i_amp1;
      sh_amp[2] = i_amp2;
      sh_amp[3] = i_amp3;
   endtask

   task automatic model_zero_outputs();
      e_mod = '0; e_step = 2'd0; e_status = 0; e_st = 0; e_sp = 0; e_done = 0;
   endtask

   task automatic model_reset();
      m_run = 0; m_k = 0; sh_mode = 0; sh_freq = 0; sh_trig = 0;
      for (int i = 0; i < 4; i++) sh_amp[i] = '0;
      model_zero_outputs();
   endtask

   task automatic model_edge();
      longint s, idx;
      if (!i_en) begin
         m_run = 0;
         model_zero_outputs();
         return;
      end
      if (!m_run) begin
         model_load();
         m_run = 1; m_k = 0; e_done = 0;
      end else begin
         m_k++;
         if (m_k == nsteps() * dwell()) begin
            m_k = 0;
            model_load();
            e_done = 1;
         end else begin
            e_done = 0;
         end
      end
      s        = m_k / dwell();
      idx      = m_k % dwell();
      e_step   = 2'(s);
      e_mod    = sh_amp[s];
      e_status = (s < nsteps() / 2);
      e_st     = (idx == 0);
      e_sp     = (idx == sh_trig);
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".mod"},    64'(o_mod_out),    64'(e_mod));
      check({tag, ".step"},   64'(o_step),       64'(e_step));
      check({tag, ".status"}, 64'(o_status),     64'(e_status));
      check({tag, ".stTrig"}, 64'(o_stepTrig),   64'(e_st));
      check({tag, ".spTrig"}, 64'(o_sampTrig),   64'(e_sp));
      check({tag, ".done"},   64'(o_cycle_done), 64'(e_done));
      check({tag, ".run"},    64'(o_dbg_running), 64'(m_run));
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick(input string tag);
      @(posedge i_clk);
      model_edge();
      #1;
      compare_all(tag);
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   task automatic config_set(input bit mode, input logic [CW-1:0] freq, input logic [CW-1:0] dly,
                             input int a0, input int a1, input int a2, input int a3);
      i_mode = mode; i_freq_cnt = freq; i_trig_dly = dly;
      i_amp0 = a0; i_amp1 = a1; i_amp2 = a2; i_amp3 = a3;
   endtask

   // called 1 time unit after a rising edge
   task automatic pulse_reset(input string tag);
      #2;
      i_rst_n = 1'b0;
      model_reset();
      #1;
      compare_all(tag);
      #1;
      i_rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int edges_to_step2;

   initial begin
      model_reset();
      #12;
      compare_all("reset");
      i_rst_n = 1'b1;
      run("idle_after_reset", 3);

      // two-state directed pattern
      config_set(1'b0, 4, 2, 100, -100, 0, 0);
      i_en = 1'b1;
      run("two_state", 24);

      // shadowing: change amp1 and freq in the middle of step 1
      i_en = 1'b0; tick("shadow_stop");
      i_en = 1'b1;
      run("shadow_pre", 6);
      i_amp1 = 55; i_freq_cnt = 2;
      run("shadow_post", 16);

      // four-state directed pattern
      i_en = 1'b0; tick("four_stop");
      config_set(1'b1, 3, 1, 10, 20, -10, -20);
      i_en = 1'b1;
      run("four_state", 26);

      // freq 0 and freq 1 with an unreachable trigger offset
      config_set(1'b1, 0, 5, 7, 8, 9, 10);
      run("freq0", 12);
      i_freq_cnt = 1;
      run("freq1", 12);
      i_trig_dly = 0;
      run("freq1_dly0", 6);

      // drop enable in step 2, then restart
      i_en = 1'b0; tick("drop_stop");
      config_set(1'b1, 3, 0, 1, 2, 3, 4);
      i_en = 1'b1;
      edges_to_step2 = 7;
      run("drop_pre", edges_to_step2);
      i_en = 1'b0;
      run("drop_edge", 2);
      i_en = 1'b1;
      run("restart", 5);

      // mode change mid-cycle
      i_mode = 1'b0;
      run("mode_change", 20);

      // asynchronous reset mid-step, then idle until enable
      pulse_reset("async_rst");
      i_en = 1'b0;
      run("rst_idle", 4);
      i_en = 1'b1;
      run("rst_restart", 8);

      // very long dwell: counter must not wrap early
      i_en = 1'b0; tick("big_stop");
      config_set(1'b0, {CW{1'b1}}, 3, -5, 5, 0, 0);
      i_en = 1'b1;
      run("big_freq", 20);

      // randomized run
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) == 0)
            config_set(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 6),
                       int'($urandom), int'($urandom), int'($urandom), int'($urandom));
         i_en = ($urandom_range(0, 24) != 0);
         tick("random");
         if ($urandom_range(0, 199) == 0) pulse_reset("random_rst");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
